// File: rtl/u_pkg.sv
// Shared types and constants for the u_share thermometer-code scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: statistics counter width/ceiling and a saturating increment helper.
// The response record u_rsp_t depends on the user's W and N, so it is declared
// in the user from its own localparams (see u_share).
package u_pkg;

  localparam int unsigned U_STAT_W = 16;
  localparam logic [U_STAT_W-1:0] U_STAT_MAX = '1;

  // Increment that sticks at the ceiling instead of wrapping to zero.
  function automatic logic [U_STAT_W-1:0] u_sat_inc(input logic [U_STAT_W-1:0] cnt);
    return (cnt == U_STAT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/u.sv
// Combinational unary/thermometer-code checker.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   i_x         W-bit candidate vector
//   o_is_unary  vector is an admitted code (0..01..1 incl. zero, optionally complements)
//   o_inv       admitted in complemented form (is_unary & msb)
module u #(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1
) (
  input  logic [W-1:0] i_x,
  output logic         o_is_unary,
  output logic         o_inv
);

  logic [W-1:0] x_inc;
  logic [W-1:0] nx;
  logic [W-1:0] nx_inc;
  logic         thermo_lo;
  logic         thermo_hi;

  always_comb begin
    x_inc  = i_x + 1'b1;
    nx     = ~i_x;
    nx_inc = nx + 1'b1;
    // x & (x+1) == 0 holds exactly for 2^k-1. Requiring msb=0 keeps all-ones
    // out of the plain form; it is only reachable as the complement of zero.
    thermo_lo  = ~i_x[W-1] & ((i_x & x_inc) == '0);
    // Complemented form: 1..10..0, which always has msb=1 (all-ones included).
    thermo_hi  = P_ADMIT_COMPLIMENT_EN & i_x[W-1] & ((nx & nx_inc) == '0);
    o_is_unary = thermo_lo | thermo_hi;
    o_inv      = o_is_unary & i_x[W-1];
  end

endmodule

// File: rtl/u_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping modulo N.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides whether the grant is taken.
//
// Ports:
//   i_vld      per-requester valid
//   i_ptr      search start index (always < N)
//   o_gnt_vld  at least one requester is valid
//   o_gnt      granted requester index
module u_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vld,
  input  logic [IW-1:0] i_ptr,
  output logic          o_gnt_vld,
  output logic [IW-1:0] o_gnt
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] keep;
  logic [2*N-1:0] masked;
  int             idx;

  always_comb begin
    // Doubling the vector turns the wrap-around search into a plain
    // lowest-set-bit search over bits [ptr .. ptr+N-1].
    dbl  = {i_vld, i_vld};
    keep = '0;
    for (int i = 0; i < 2*N; i++) begin
      keep[i] = (i >= int'(i_ptr));
    end
    masked = dbl & keep;

    idx = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) idx = i;
    end
    if (idx >= N) idx = idx - N;

    o_gnt_vld = |i_vld;
    o_gnt     = IW'(idx);
  end

endmodule

// File: rtl/u_share.sv
// Round-robin time-share of one thermometer-code checker among N requesters, with accept/reject stats.
// Latency: 1 cycle from accept to registered verdict on the response channel.
// Backpressure: a held response (o_rsp_vld & ~i_rsp_rdy) freezes o_rsp_* and drops all o_req_rdy.
//
// Ports:
//   i_clk, i_arst_n          clock, asynchronous active-low reset
//   i_req_vld/i_req_x        per-requester valid and W-bit vector (requester k at [k*W +: W])
//   o_req_rdy                per-requester ready, one-hot or zero
//   o_rsp_vld/i_rsp_rdy      response handshake
//   o_rsp_id/x/is_unary/inv  registered verdict tagged with requester index
//   i_stat_clr               synchronous clear of both counters (wins over increment)
//   o_acc_cnt/o_rej_cnt      saturating admitted/rejected counts
module u_share
  import u_pkg::*;
#(
  parameter  int W                     = 16,
  parameter  int N                     = 4,
  parameter  bit P_ADMIT_COMPLIMENT_EN = 1'b1,
  localparam int IW                    = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic [N-1:0]        i_req_vld,
  input  logic [N*W-1:0]      i_req_x,
  output logic [N-1:0]        o_req_rdy,
  output logic                o_rsp_vld,
  input  logic                i_rsp_rdy,
  output logic [IW-1:0]       o_rsp_id,
  output logic [W-1:0]        o_rsp_x,
  output logic                o_rsp_is_unary,
  output logic                o_rsp_inv,
  input  logic                i_stat_clr,
  output logic [U_STAT_W-1:0] o_acc_cnt,
  output logic [U_STAT_W-1:0] o_rej_cnt
);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  x;
    logic          is_unary;
    logic          inv;
  } u_rsp_t;

  logic                gnt_vld;
  logic [IW-1:0]       gnt;
  logic [W-1:0]        gnt_x;
  logic                chk_unary;
  logic                chk_inv;
  logic                can_load;
  logic                accept;

  u_rsp_t              rsp_q,     rsp_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [IW-1:0]       ptr_q,     ptr_d;
  logic [U_STAT_W-1:0] acc_q,     acc_d;
  logic [U_STAT_W-1:0] rej_q,     rej_d;

  u_rr_pick #(
    .N (N)
  ) u_pick (
    .i_vld     (i_req_vld),
    .i_ptr     (ptr_q),
    .o_gnt_vld (gnt_vld),
    .o_gnt     (gnt)
  );

  // Only the granted vector reaches the shared checker.
  always_comb begin
    gnt_x = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == IW'(k)) gnt_x = i_req_x[k*W +: W];
    end
  end

  u #(
    .W                     (W),
    .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
  ) u_chk (
    .i_x        (gnt_x),
    .o_is_unary (chk_unary),
    .o_inv      (chk_inv)
  );

  // The response slot can take a new entry when empty or being drained this
  // cycle; ready never looks at i_req_x.
  assign can_load = ~rsp_vld_q | i_rsp_rdy;

  always_comb begin
    o_req_rdy = '0;
    for (int k = 0; k < N; k++) begin
      o_req_rdy[k] = gnt_vld & can_load & (gnt == IW'(k));
    end
  end

  assign accept = |(i_req_vld & o_req_rdy);

  always_comb begin
    rsp_d     = rsp_q;
    rsp_vld_d = rsp_vld_q;
    ptr_d     = ptr_q;
    if (accept) begin
      rsp_vld_d      = 1'b1;
      rsp_d.id       = gnt;
      rsp_d.x        = gnt_x;
      rsp_d.is_unary = chk_unary;
      rsp_d.inv      = chk_inv;
      // Explicit wrap so non-power-of-two N never lands on an unused index.
      ptr_d          = (gnt == IW'(N-1)) ? '0 : gnt + 1'b1;
    end else if (i_rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    rej_d = rej_q;
    if (i_stat_clr) begin
      acc_d = '0;
      rej_d = '0;
    end else if (accept) begin
      if (chk_unary) acc_d = u_sat_inc(acc_q);
      else           rej_d = u_sat_inc(rej_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      ptr_q     <= '0;
      acc_q     <= '0;
      rej_q     <= '0;
    end else begin
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
      ptr_q     <= ptr_d;
      acc_q     <= acc_d;
      rej_q     <= rej_d;
    end
  end

  assign o_rsp_vld      = rsp_vld_q;
  assign o_rsp_id       = rsp_q.id;
  assign o_rsp_x        = rsp_q.x;
  assign o_rsp_is_unary = rsp_q.is_unary;
  assign o_rsp_inv      = rsp_q.inv;
  assign o_acc_cnt      = acc_q;
  assign o_rej_cnt      = rej_q;

endmodule

// File: tb/tb_u_share.sv
// Self-checking bench for u_share: directed vector table plus hand-written multi-cycle sequences.
// Three instances: N=4 with complements admitted, N=4 without, N=3 for wrap order.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_u_share;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] x;
    logic        u;
    logic        inv;
    logic        u_dis;
  } vec_t;

  logic        clk;
  logic        arst_n;
  logic [3:0]  req_vld;
  logic [63:0] req_x;
  logic        rsp_rdy;
  logic        stat_clr;

  logic [3:0]  req_rdy;
  logic        rsp_vld, rsp_u, rsp_inv;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_x, acc, rej;

  logic [3:0]  req_rdy0;
  logic        rsp_vld0, rsp_u0, rsp_inv0;
  logic [1:0]  rsp_id0;
  logic [15:0] rsp_x0, acc0, rej0;

  logic [2:0]  vld3;
  logic [47:0] x3;
  logic [2:0]  rdy3;
  logic        rsp_vld3, rsp_u3, rsp_inv3;
  logic [1:0]  rsp_id3;
  logic [15:0] rsp_x3, acc3, rej3;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_acc, exp_rej, exp_acc0, exp_rej0, exp_ptr, e;
  vec_t tbl [13];

  u_share #(.W(16), .N(4), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_req_vld(req_vld), .i_req_x(req_x),
    .o_req_rdy(req_rdy), .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_id(rsp_id),
    .o_rsp_x(rsp_x), .o_rsp_is_unary(rsp_u), .o_rsp_inv(rsp_inv), .i_stat_clr(stat_clr),
    .o_acc_cnt(acc), .o_rej_cnt(rej)
  );

  u_share #(.W(16), .N(4), .P_ADMIT_COMPLIMENT_EN(1'b0)) dut0 (
    .i_clk(clk), .i_arst_n(arst_n), .i_req_vld(req_vld), .i_req_x(req_x),
    .o_req_rdy(req_rdy0), .o_rsp_vld(rsp_vld0), .i_rsp_rdy(rsp_rdy), .o_rsp_id(rsp_id0),
    .o_rsp_x(rsp_x0), .o_rsp_is_unary(rsp_u0), .o_rsp_inv(rsp_inv0), .i_stat_clr(stat_clr),
    .o_acc_cnt(acc0), .o_rej_cnt(rej0)
  );

  u_share #(.W(16), .N(3), .P_ADMIT_COMPLIMENT_EN(1'b1)) dut3 (
    .i_clk(clk), .i_arst_n(arst_n), .i_req_vld(vld3), .i_req_x(x3),
    .o_req_rdy(rdy3), .o_rsp_vld(rsp_vld3), .i_rsp_rdy(rsp_rdy), .o_rsp_id(rsp_id3),
    .o_rsp_x(rsp_x3), .o_rsp_is_unary(rsp_u3), .o_rsp_inv(rsp_inv3), .i_stat_clr(stat_clr),
    .o_acc_cnt(acc3), .o_rej_cnt(rej3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          id     x         u     inv   u_dis
    tbl[0]  = '{2'd1, 16'h00FF, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{2'd2, 16'hFF00, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2'd3, 16'h00F0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{2'd1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{2'd2, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{2'd3, 16'h8000, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2'd0, 16'h0001, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{2'd1, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{2'd2, 16'h0101, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'd3, 16'h8001, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'd0, 16'hFFF7, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{2'd1, 16'h0003, 1'b1, 1'b0, 1'b1};

    arst_n   = 1'b1;
    req_vld  = '0;
    req_x    = '0;
    vld3     = '0;
    x3       = '0;
    rsp_rdy  = 1'b1;
    stat_clr = 1'b0;
    exp_acc  = 0;
    exp_rej  = 0;
    exp_acc0 = 0;
    exp_rej0 = 0;
    exp_ptr  = 0;

    // Reset state, observed while reset is held.
    #2 arst_n = 1'b0;
    #8;
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_flds", 32'({rsp_id, rsp_x, rsp_u, rsp_inv}), 32'd0);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_rej", 32'(rej), 32'd0);
    #2 arst_n = 1'b1;
    tick();
    chk("idle_rdy", 32'(req_rdy), 32'd0);

    // Table: one requester at a time, full-rate responses.
    for (int i = 0; i < 13; i++) begin
      req_vld = 4'b0001 << tbl[i].id;
      req_x   = '0;
      req_x[int'(tbl[i].id)*16 +: 16] = tbl[i].x;
      #1;
      chk("tbl_rdy", 32'(req_rdy), 32'(4'b0001 << tbl[i].id));
      chk("tbl_rdy_dis", 32'(req_rdy0), 32'(4'b0001 << tbl[i].id));
      tick();
      exp_acc  += int'(tbl[i].u);
      exp_rej  += int'(!tbl[i].u);
      exp_acc0 += int'(tbl[i].u_dis);
      exp_rej0 += int'(!tbl[i].u_dis);
      exp_ptr   = (int'(tbl[i].id) + 1) % 4;
      chk("tbl_rsp_vld", 32'(rsp_vld), 32'd1);
      chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[i].id));
      chk("tbl_rsp_x", 32'(rsp_x), 32'(tbl[i].x));
      chk("tbl_is_unary", 32'(rsp_u), 32'(tbl[i].u));
      chk("tbl_inv", 32'(rsp_inv), 32'(tbl[i].inv));
      chk("tbl_acc", 32'(acc), 32'(exp_acc));
      chk("tbl_rej", 32'(rej), 32'(exp_rej));
      chk("tbl_dis_rsp", 32'({rsp_vld0, rsp_id0, rsp_x0, rsp_u0, rsp_inv0}),
          32'({1'b1, tbl[i].id, tbl[i].x, tbl[i].u_dis, 1'b0}));
    end
    chk("tbl_dis_acc", 32'(acc0), 32'(exp_acc0));
    chk("tbl_dis_rej", 32'(rej0), 32'(exp_rej0));

    // Drain with no new accept clears valid.
    req_vld = '0;
    tick();
    chk("drain_vld", 32'(rsp_vld), 32'd0);

    // Fairness: all four valid, one response per cycle in rotating order.
    req_x   = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    req_vld = 4'hF;
    for (int i = 0; i < 8; i++) begin
      e = (exp_ptr + i) % 4;
      #1;
      chk("rr_rdy", 32'(req_rdy), 32'(1) << e);
      tick();
      exp_acc++;
      chk("rr_vld", 32'(rsp_vld), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(e));
      chk("rr_x", 32'(rsp_x), (32'(1) << (e + 1)) - 32'd1);
    end
    chk("rr_acc", 32'(acc), 32'(exp_acc));
    req_vld = '0;

    // N=3 wrap order 0,1,2,0,1,2.
    vld3 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("n3_rdy", 32'(rdy3), 32'(1) << (i % 3));
      tick();
      chk("n3_rsp", 32'({rsp_vld3, rsp_id3, rsp_x3, rsp_u3, rsp_inv3}),
          32'({1'b1, 2'(i % 3), 16'h0000, 1'b1, 1'b0}));
    end
    vld3 = '0;
    chk("n3_acc", 32'(acc3), 32'd6);
    chk("n3_rej", 32'(rej3), 32'd0);

    // Backpressure: pointer sits at 2 here, requesters 0 and 2 valid.
    req_x   = {16'h0000, 16'h0FFF, 16'h0000, 16'h003F};
    req_vld = 4'b0101;
    #1;
    chk("bp_first_rdy", 32'(req_rdy), 32'b0100);
    tick();
    exp_acc++;
    chk("bp_first_id", 32'(rsp_id), 32'd2);
    rsp_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_rdy", 32'(req_rdy), 32'd0);
      chk("bp_hold_rsp", 32'({rsp_vld, rsp_id, rsp_x, rsp_u, rsp_inv}),
          32'({1'b1, 2'd2, 16'h0FFF, 1'b1, 1'b0}));
      tick();
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(req_rdy), 32'b0001);
    tick();
    exp_acc++;
    chk("bp_release_rsp", 32'({rsp_vld, rsp_id, rsp_x}), 32'({1'b1, 2'd0, 16'h003F}));
    req_vld = '0;
    tick();
    chk("bp_drain_vld", 32'(rsp_vld), 32'd0);
    chk("bp_acc", 32'(acc), 32'(exp_acc));

    // Clear coinciding with an accept: clear wins.
    req_x    = '0;
    req_vld  = 4'b0001;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    req_vld  = '0;
    chk("clr_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("clr_acc", 32'(acc), 32'd0);
    chk("clr_rej", 32'(rej), 32'd0);

    // Saturation: 65534 admitted zeros, then three more.
    req_vld = 4'hF;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre_acc", 32'(acc), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_acc", 32'(acc), 32'hFFFF);
      chk("sat_rej", 32'(rej), 32'd0);
    end

    // Reset mid-stream: response dropped, pointer back to 0.
    tick();
    arst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(rsp_vld), 32'd0);
    chk("mrst_flds", 32'({rsp_id, rsp_x, rsp_u, rsp_inv}), 32'd0);
    chk("mrst_acc", 32'(acc), 32'd0);
    #1 arst_n = 1'b1;
    #1;
    chk("mrst_rdy", 32'(req_rdy), 32'b0001);
    tick();
    chk("mrst_id0", 32'({rsp_vld, rsp_id}), 32'({1'b1, 2'd0}));
    tick();
    chk("mrst_id1", 32'({rsp_vld, rsp_id}), 32'({1'b1, 2'd1}));
    req_vld = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/u_share.md
# u_share

Round-robin scheduler that time-shares one combinational unary/thermometer-code checker among N requesters. Each requester presents a W-bit vector with a valid/ready handshake; the block grants one per cycle, evaluates it, and returns a registered verdict tagged with the requester id on a single response channel with backpressure. It also keeps saturating accept/reject statistics. It sits between producer agents and any consumer that must reject malformed thermometer codes.

## Interface
- W, 16: vector bit-width, at least 2.
- N, 4: number of requesters, at least 2.
- P_ADMIT_COMPLIMENT_EN, 1: also admit complemented codes.
- IW, $clog2(N): id width (localparam).
- i_clk  in  1  clock.
- i_arst_n  in  1  reset; one clock, asynchronous active-low reset.
- i_req_vld  in  N  per-requester valid.
- i_req_x  in  N×W  per-requester vector, packed, requester k at [k*W +: W].
- o_req_rdy  out  N  per-requester ready; one-hot or zero.
- o_rsp_vld  out  1  response valid.
- i_rsp_rdy  in  1  response consumer ready.
- o_rsp_id  out  IW  requester index of the response.
- o_rsp_x  out  W  echoed vector.
- o_rsp_is_unary  out  1  vector is an admitted code.
- o_rsp_inv  out  1  admitted in complemented form: is_unary & x[W-1].
- i_stat_clr  in  1  synchronous clear of the statistics counters.
- o_acc_cnt  out  16  count of admitted vectors, saturating.
- o_rej_cnt  out  16  count of rejected vectors, saturating.

## Operation
- Admission rule:
  - Admit the all-zero vector.
  - Admit any vector matching 0…01…1 with at least one 1 in the low bits.
  - When P_ADMIT_COMPLIMENT_EN is set, also admit the bitwise complements of these, including all-ones.
  - Reject everything else.
- Arbitration:
  - Round-robin over i_req_vld, starting at pointer `ptr` (IW bits) and searching upward with modulo-N wrap.
  - The first valid requester found is the grant `g`.
  - With no valid requester there is no grant.
- Ready: o_req_rdy[g] = grant_exists & (~o_rsp_vld | i_rsp_rdy). All other ready bits are 0.
- Accept event: i_req_vld[g] & o_req_rdy[g]. On accept:
  - Load the response register with id g, the vector, the verdict and the inverse flag.
  - Set o_rsp_vld.
  - Set ptr to (g+1) mod N. When N is not a power of two, wrap explicitly.
- Response drain: o_rsp_vld & i_rsp_rdy with no accept in the same cycle clears o_rsp_vld.
- Accept and drain in the same cycle: the register reloads with the new response, so full throughput is one per cycle.
- ptr is unchanged when no accept occurs.
- Response stability: while o_rsp_vld & ~i_rsp_rdy, all o_rsp_* fields hold stable.
- Statistics:
  - Update on accept, not on drain.
  - o_acc_cnt increments on an admitted vector; o_rej_cnt increments on a rejected one.
  - Both saturate at 16'hFFFF.
  - i_stat_clr zeroes both counters and takes priority over an increment in the same cycle.
- Requester handshake rules:
  - A requester must hold i_req_x stable while i_req_vld is high and it is not yet accepted.
  - i_req_vld does not depend on o_req_rdy.

## Timing
- Response latency: 1 cycle. Accept at edge t drives o_rsp_vld with the fields from t.
- Throughput: 1 vector per cycle while i_rsp_rdy is high.
- o_req_rdy is combinational from i_req_vld, ptr, o_rsp_vld and i_rsp_rdy. There is no path from i_req_x to o_req_rdy.
- Reset values:
  - o_rsp_vld = 0, ptr = 0.
  - o_rsp_id, o_rsp_x, o_rsp_is_unary, o_rsp_inv = 0.
  - Both counters = 0.
  - o_req_rdy evaluates with o_rsp_vld = 0.
- Reset asserted mid-transfer: the pending response is discarded without drain and the counters are not rolled back.

## Structure
- Shared package `u_pkg`: stat counter width constant (16) and a `u_rsp_t` struct {id, x, is_unary, inv}, parameterised through localparams in the user.
- Reuse the existing combinational checker `u` (one instance, on the muxed granted vector) for the admission verdict.
- One new sub-module, `u_rr_pick`: a combinational round-robin picker taking the valid vector and ptr and returning grant_exists and g. It uses a doubled-vector mask-and-priority scheme.

## Test plan
- Single requester, W=16: requester 1 sends 16'h00FF, i_rsp_rdy=1 -> next cycle o_rsp_vld=1, id=1, is_unary=1, inv=0, acc=1.
- Complement and reject: 16'hFF00 then 16'h00F0 -> is_unary=1 with inv=1, then is_unary=0; acc=1, rej=1. With P_ADMIT_COMPLIMENT_EN=0, 16'hFF00 is rejected.
- Boundary codes:
  - 16'h0000 -> is_unary=1, inv=0.
  - 16'hFFFF -> is_unary=1, inv=1 (enabled); rejected when disabled.
  - 16'h7FFF -> is_unary=1, inv=0.
- Fairness: all 4 requesters continuously valid with i_rsp_rdy=1 -> ids 0,1,2,3,0,… with one response per cycle. With N=3, the sequence wraps 0,1,2,0.
- Backpressure: hold i_rsp_rdy=0 for 5 cycles with two requesters valid -> o_req_rdy=0 and response fields stable. Release -> the queued grant is accepted in the same cycle as the drain.
- Saturation and clear: preload acc to 16'hFFFE, admit 3 vectors -> acc holds 16'hFFFF. Assert i_stat_clr in the same cycle as an accept -> both counters read 0. Assert reset mid-stream -> o_rsp_vld=0 and ptr=0.
